// File: rtl/rx_dispatch.sv
// rtl/rx_dispatch.sv - routes whole MAC RX frames to the tsn or pl2ps sink by EtherType
module rx_dispatch #(
    parameter int          AXIS_DATA_WIDTH = 8,
    parameter logic [15:0] TSN_ETHERTYPE   = 16'h88B5,
    parameter bit          FWD_OTHER       = 1'b1
) (
    input  logic                       axis_aclk,
    input  logic                       axis_reset,
    input  logic [AXIS_DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic                       rx_axis_tvalid,
    input  logic                       rx_axis_tlast,
    output logic                       rx_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] rx_axis_tsn_tdata,
    output logic                       rx_axis_tsn_tvalid,
    output logic                       rx_axis_tsn_tlast,
    input  logic                       rx_axis_tsn_tready,
    output logic [AXIS_DATA_WIDTH-1:0] rx_axis_pl2ps_tdata,
    output logic                       rx_axis_pl2ps_tvalid,
    output logic                       rx_axis_pl2ps_tlast,
    input  logic                       rx_axis_pl2ps_tready,
    output logic [31:0]                cnt_tsn,
    output logic [31:0]                cnt_pl2ps,
    output logic [31:0]                cnt_drop
);

    typedef enum logic [2:0] {S_HDR, S_DECIDE, S_REPLAY, S_PASS, S_DROP} state_t;

    state_t                     state, state_nxt;
    logic [AXIS_DATA_WIDTH-1:0] hdr_buf [0:17];
    logic [4:0]                 hdr_idx;
    logic [4:0]                 rp_idx;
    logic                       hdr_last;
    logic                       sel;
    logic [AXIS_DATA_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic                       out_last;

    logic        rx_fire;
    logic        tag_now;
    logic        hdr_done;
    logic        vlan;
    logic [4:0]  hdr_end;
    logic [15:0] ethertype;
    logic        route_tsn;
    logic        route_pl2ps;
    logic        sel_tready;
    logic        replay_fire;

    assign rx_fire     = rx_axis_tvalid && rx_axis_tready;
    assign tag_now     = {hdr_buf[12], rx_axis_tdata} == 16'h8100;
    assign hdr_done    = (hdr_idx == 5'd13 && !tag_now) || hdr_idx == 5'd17;
    assign vlan        = {hdr_buf[12], hdr_buf[13]} == 16'h8100;
    assign hdr_end     = vlan ? 5'd17 : 5'd13;
    assign ethertype   = vlan ? {hdr_buf[16], hdr_buf[17]} : {hdr_buf[12], hdr_buf[13]};
    assign route_tsn   = ethertype == TSN_ETHERTYPE;
    assign route_pl2ps = !route_tsn && (FWD_OTHER || ethertype == 16'h88F7);
    assign sel_tready  = sel ? rx_axis_pl2ps_tready : rx_axis_tsn_tready;
    assign replay_fire = out_valid && sel_tready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:    if (rx_fire && hdr_done) state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (route_tsn || route_pl2ps) state_nxt = S_REPLAY;
                else if (hdr_last)            state_nxt = S_HDR;
                else                          state_nxt = S_DROP;
            end
            S_REPLAY: if (replay_fire && rp_idx == hdr_end) state_nxt = hdr_last ? S_HDR : S_PASS;
            S_PASS, S_DROP: if (rx_fire && rx_axis_tlast) state_nxt = S_HDR;
            default:  state_nxt = S_HDR;
        endcase
    end

    // Header storage needs no reset: it is always rewritten before being read.
    always_ff @(posedge axis_aclk) begin
        if (state == S_HDR && rx_fire) hdr_buf[hdr_idx] <= rx_axis_tdata;
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state     <= S_HDR;
            hdr_idx   <= 5'd0;
            rp_idx    <= 5'd0;
            hdr_last  <= 1'b0;
            sel       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt_tsn   <= 32'd0;
            cnt_pl2ps <= 32'd0;
            cnt_drop  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_HDR: if (rx_fire) begin
                    if (hdr_done) begin
                        hdr_last <= rx_axis_tlast;
                        hdr_idx  <= 5'd0;
                    end else if (rx_axis_tlast) begin
                        cnt_drop <= cnt_drop + 32'd1;
                        hdr_idx  <= 5'd0;
                    end else begin
                        hdr_idx  <= hdr_idx + 5'd1;
                    end
                end
                S_DECIDE: begin
                    sel <= route_pl2ps;
                    if (route_tsn || route_pl2ps) begin
                        out_valid <= 1'b1;
                        out_data  <= hdr_buf[0];
                        out_last  <= 1'b0;
                        rp_idx    <= 5'd0;
                    end else if (hdr_last) begin
                        cnt_drop <= cnt_drop + 32'd1;
                    end
                end
                S_REPLAY: if (replay_fire) begin
                    if (rp_idx == hdr_end) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        if (hdr_last && sel)  cnt_pl2ps <= cnt_pl2ps + 32'd1;
                        if (hdr_last && !sel) cnt_tsn   <= cnt_tsn + 32'd1;
                    end else begin
                        rp_idx   <= rp_idx + 5'd1;
                        out_data <= hdr_buf[rp_idx + 5'd1];
                        out_last <= hdr_last && (rp_idx + 5'd1 == hdr_end);
                    end
                end
                S_PASS: if (rx_fire && rx_axis_tlast) begin
                    if (sel) cnt_pl2ps <= cnt_pl2ps + 32'd1;
                    else     cnt_tsn   <= cnt_tsn + 32'd1;
                end
                S_DROP: if (rx_fire && rx_axis_tlast) cnt_drop <= cnt_drop + 32'd1;
                default: ;
            endcase
        end
    end

    // PASS is a combinational path from the MAC, REPLAY drives from the header registers.
    logic                       drv_valid;
    logic                       drv_last;
    logic [AXIS_DATA_WIDTH-1:0] drv_data;

    always_comb begin
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_data  = '0;
        if (state == S_REPLAY) begin
            drv_valid = out_valid;
            drv_last  = out_last;
            drv_data  = out_data;
        end else if (state == S_PASS) begin
            drv_valid = rx_axis_tvalid;
            drv_last  = rx_axis_tlast;
            drv_data  = rx_axis_tdata;
        end
    end

    assign rx_axis_tsn_tvalid   = !axis_reset && !sel && drv_valid;
    assign rx_axis_tsn_tlast    = !axis_reset && !sel && drv_last;
    assign rx_axis_tsn_tdata    = (!axis_reset && !sel) ? drv_data : '0;
    assign rx_axis_pl2ps_tvalid = !axis_reset && sel && drv_valid;
    assign rx_axis_pl2ps_tlast  = !axis_reset && sel && drv_last;
    assign rx_axis_pl2ps_tdata  = (!axis_reset && sel) ? drv_data : '0;
    assign rx_axis_tready       = !axis_reset && (state == S_HDR || state == S_DROP ||
                                                  (state == S_PASS && sel_tready));

endmodule

// File: tb/tb_rx_dispatch.sv
// tb/tb_rx_dispatch.sv - randomized frame stimulus checked against a frame-level routing model
module tb_rx_dispatch;

    localparam logic [15:0] TSN_ET = 16'h88B5;
    localparam bit          FWD    = 1'b0;

    logic        axis_aclk = 1'b0;
    logic        axis_reset = 1'b1;
    logic [7:0]  rx_axis_tdata = 8'd0;
    logic        rx_axis_tvalid = 1'b0;
    logic        rx_axis_tlast = 1'b0;
    logic        rx_axis_tready;
    logic [7:0]  rx_axis_tsn_tdata;
    logic        rx_axis_tsn_tvalid;
    logic        rx_axis_tsn_tlast;
    logic        rx_axis_tsn_tready = 1'b1;
    logic [7:0]  rx_axis_pl2ps_tdata;
    logic        rx_axis_pl2ps_tvalid;
    logic        rx_axis_pl2ps_tlast;
    logic        rx_axis_pl2ps_tready = 1'b1;
    logic [31:0] cnt_tsn, cnt_pl2ps, cnt_drop;

    rx_dispatch #(.AXIS_DATA_WIDTH(8), .TSN_ETHERTYPE(TSN_ET), .FWD_OTHER(FWD)) dut (
        .axis_aclk(axis_aclk), .axis_reset(axis_reset),
        .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tlast(rx_axis_tlast), .rx_axis_tready(rx_axis_tready),
        .rx_axis_tsn_tdata(rx_axis_tsn_tdata), .rx_axis_tsn_tvalid(rx_axis_tsn_tvalid),
        .rx_axis_tsn_tlast(rx_axis_tsn_tlast), .rx_axis_tsn_tready(rx_axis_tsn_tready),
        .rx_axis_pl2ps_tdata(rx_axis_pl2ps_tdata), .rx_axis_pl2ps_tvalid(rx_axis_pl2ps_tvalid),
        .rx_axis_pl2ps_tlast(rx_axis_pl2ps_tlast), .rx_axis_pl2ps_tready(rx_axis_pl2ps_tready),
        .cnt_tsn(cnt_tsn), .cnt_pl2ps(cnt_pl2ps), .cnt_drop(cnt_drop)
    );

    always #5 axis_aclk = ~axis_aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_tsn[$];
    logic [8:0] exp_pl[$];
    logic [7:0] fr[$];
    int m_tsn = 0, m_pl = 0, m_drop = 0;
    bit mon_en = 1'b1;
    int tsn_mode = 0, pl_mode = 0;

    initial forever begin
        @(posedge axis_aclk);
        #1;
        case (tsn_mode)
            0: rx_axis_tsn_tready = 1'b1;
            1: rx_axis_tsn_tready = 1'($urandom_range(1));
            default: rx_axis_tsn_tready = !rx_axis_tsn_tready;
        endcase
        case (pl_mode)
            0: rx_axis_pl2ps_tready = 1'b1;
            1: rx_axis_pl2ps_tready = 1'($urandom_range(1));
            default: rx_axis_pl2ps_tready = !rx_axis_pl2ps_tready;
        endcase
    end

    logic [8:0] e_tsn, e_pl;
    always @(negedge axis_aclk) begin
        if (mon_en && !axis_reset) begin
            if (rx_axis_tsn_tvalid && rx_axis_tsn_tready) begin
                if (exp_tsn.size() == 0) check("tsn_unexpected_byte", 32'd1, 32'd0);
                else begin
                    e_tsn = exp_tsn.pop_front();
                    check("tsn_byte", 32'({rx_axis_tsn_tlast, rx_axis_tsn_tdata}), 32'(e_tsn));
                end
            end
            if (rx_axis_pl2ps_tvalid && rx_axis_pl2ps_tready) begin
                if (exp_pl.size() == 0) check("pl2ps_unexpected_byte", 32'd1, 32'd0);
                else begin
                    e_pl = exp_pl.pop_front();
                    check("pl2ps_byte", 32'({rx_axis_pl2ps_tlast, rx_axis_pl2ps_tdata}), 32'(e_pl));
                end
            end
            if (rx_axis_tsn_tvalid)
                check("pl2ps_quiet", 32'({rx_axis_pl2ps_tvalid, rx_axis_pl2ps_tlast, rx_axis_pl2ps_tdata}), 32'd0);
            if (rx_axis_pl2ps_tvalid)
                check("tsn_quiet", 32'({rx_axis_tsn_tvalid, rx_axis_tsn_tlast, rx_axis_tsn_tdata}), 32'd0);
        end
    end

    // 0 = tsn, 1 = pl2ps, 2 = drop
    function automatic int route(input logic [7:0] q[$]);
        logic [15:0] et;
        bit tag;
        if (q.size() < 14) return 2;
        tag = {q[12], q[13]} == 16'h8100;
        if (tag && q.size() < 18) return 2;
        et = tag ? {q[16], q[17]} : {q[12], q[13]};
        if (et == TSN_ET) return 0;
        if (FWD || et == 16'h88F7) return 1;
        return 2;
    endfunction

    function automatic logic [15:0] pick_et();
        case ($urandom_range(3))
            0: return 16'h88B5;
            1: return 16'h8100;
            2: return 16'h88F7;
            default: return 16'h0800;
        endcase
    endfunction

    task automatic make_frame(input int len, input logic [15:0] et1, input logic [15:0] et2);
        fr.delete();
        for (int i = 0; i < len; i++) begin
            case (i)
                12: fr.push_back(et1[15:8]);
                13: fr.push_back(et1[7:0]);
                16: fr.push_back(et2[15:8]);
                17: fr.push_back(et2[7:0]);
                default: fr.push_back(8'($urandom));
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap_pct);
        bit acc;
        int n;
        while (int'($urandom_range(99)) < gap_pct) begin
            rx_axis_tvalid = 1'b0;
            @(posedge axis_aclk);
            #1;
        end
        rx_axis_tdata  = b;
        rx_axis_tlast  = last;
        rx_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge axis_aclk);
            acc = rx_axis_tready;
            @(posedge axis_aclk);
            #1;
            if (acc) break;
            n++;
            if (n > 2000) begin
                check("rx_tready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        int r;
        r = route(fr);
        for (int i = 0; i < fr.size(); i++) begin
            if (r == 0) exp_tsn.push_back({i == fr.size() - 1, fr[i]});
            if (r == 1) exp_pl.push_back({i == fr.size() - 1, fr[i]});
        end
        if (r == 0) m_tsn++;
        else if (r == 1) m_pl++;
        else m_drop++;
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], i == fr.size() - 1, gap_pct);
    endtask

    task automatic drain_and_count(input string tag);
        int n;
        n = 0;
        while ((exp_tsn.size() != 0 || exp_pl.size() != 0) && n < 5000) begin
            @(posedge axis_aclk);
            #1;
            n++;
        end
        if (n >= 5000) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
        repeat (3) @(posedge axis_aclk);
        #1;
        check({tag, "_cnt_tsn"}, cnt_tsn, 32'(m_tsn));
        check({tag, "_cnt_pl2ps"}, cnt_pl2ps, 32'(m_pl));
        check({tag, "_cnt_drop"}, cnt_drop, 32'(m_drop));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge axis_aclk);
        #1;
        check("reset_rx_tready", 32'(rx_axis_tready), 32'd0);
        check("reset_tsn_out", 32'({rx_axis_tsn_tvalid, rx_axis_tsn_tlast, rx_axis_tsn_tdata}), 32'd0);
        check("reset_pl2ps_out", 32'({rx_axis_pl2ps_tvalid, rx_axis_pl2ps_tlast, rx_axis_pl2ps_tdata}), 32'd0);
        check("reset_counters", cnt_tsn | cnt_pl2ps | cnt_drop, 32'd0);
        axis_reset = 1'b0;
        @(posedge axis_aclk);
        #1;

        make_frame(64, 16'h88B5, 16'h0000);
        send_frame(0);
        drain_and_count("t1_tsn64");

        make_frame(60, 16'h8100, 16'h88F7);
        send_frame(0);
        make_frame(60, 16'h8100, 16'h0800);
        send_frame(0);
        drain_and_count("t2_vlan");

        make_frame(10, 16'h88B5, 16'h0000);
        send_frame(0);
        make_frame(64, 16'h88B5, 16'h0000);
        send_frame(0);
        drain_and_count("t3_runt");

        make_frame(14, 16'h88B5, 16'h0000);
        send_frame(0);
        @(negedge axis_aclk);
        check("t4_decide_gap", 32'(rx_axis_tsn_tvalid), 32'd0);
        @(negedge axis_aclk);
        check("t4_first_byte_latency", 32'(rx_axis_tsn_tvalid), 32'd1);
        drain_and_count("t4_tsn14");

        tsn_mode = 2;
        make_frame(100, 16'h88B5, 16'h0000);
        send_frame(10);
        drain_and_count("t5_toggle");
        tsn_mode = 0;

        mon_en = 1'b0;
        make_frame(64, 16'h88B5, 16'h0000);
        for (int i = 0; i < 30; i++) send_byte(fr[i], 1'b0, 0);
        axis_reset = 1'b1;
        @(negedge axis_aclk);
        check("t6_rx_tready_in_reset", 32'(rx_axis_tready), 32'd0);
        check("t6_tsn_out_in_reset", 32'({rx_axis_tsn_tvalid, rx_axis_tsn_tlast, rx_axis_tsn_tdata}), 32'd0);
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("t6_counters_cleared", cnt_tsn | cnt_pl2ps | cnt_drop, 32'd0);
        m_tsn = 0; m_pl = 0; m_drop = 0;
        @(posedge axis_aclk);
        #1;
        axis_reset = 1'b0;
        mon_en = 1'b1;
        make_frame(20, 16'h88B5, 16'h0000);
        send_frame(0);
        drain_and_count("t6_after_reset");

        for (int f = 0; f < 40; f++) begin
            int len;
            tsn_mode = $urandom_range(2);
            pl_mode  = $urandom_range(2);
            case ($urandom_range(2))
                0: len = $urandom_range(1, 13);
                1: len = $urandom_range(14, 20);
                default: len = $urandom_range(21, 80);
            endcase
            make_frame(len, pick_et(), pick_et());
            send_frame($urandom_range(0, 30));
        end
        drain_and_count("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
